fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the instruction memory.
- Holds the byte PC and drives the 6-bit word address into the combinational instruction ROM.
- Registers the returned instruction and its PC into a single-entry output buffer for decode, using a valid/ready handshake.
- Supports branch/jump redirect with flush, start/halt control, and halt-instruction detection.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage in front of a combinational instruction ROM.
// Holds the byte PC, presents the word address to the ROM and registers the
// returned instruction and its PC into a single-entry valid/ready buffer for decode.
// Supports redirect with flush, start/halt control and halt-instruction detection.
//
// Optional feature macro: FETCH_PERF_EN (adds the fetch_count output).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               pulse: IDLE -> RUN
//   imem_addr[5:0]      word address to the ROM (pc[7:2])
//   imem_instr[31:0]    instruction returned by the ROM for imem_addr
//   redirect_valid      branch/jump taken this cycle (highest priority)
//   redirect_pc[31:0]   target byte address, bits [1:0] ignored
//   out_valid           out_instr/out_pc hold a valid instruction
//   out_ready           decode accepts this cycle
//   out_instr[31:0]     registered instruction
//   out_pc[31:0]        byte PC of out_instr
//   halted              high while in HALTED
//   fetch_count[31:0]   accepted-instruction counter (FETCH_PERF_EN only)
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned PC_W   = 32;
    localparam int unsigned ADDR_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_d;
    logic [31:0]     instr_d;
    logic [PC_W-1:0] opc_d;
    logic            halted_d;
    logic            fire;

    // Word address is a straight slice of the byte PC, so it wraps every 256 bytes.
    assign imem_addr = pc_q[ADDR_W+1:2];

    // Next-state, PC and output-buffer logic; redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = out_valid;
        instr_d  = out_instr;
        opc_d    = out_pc;
        halted_d = halted;
        fire     = 1'b0;

        if (redirect_valid) begin
            // Flush the buffered entry even if decode is ready this cycle.
            pc_d    = redirect_pc & ~PC_W'(3);
            valid_d = 1'b0;
            if (state_q == S_IDLE && !start) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    fire = !out_valid || out_ready;
                    if (fire) begin
                        instr_d = imem_instr;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(4);
                        if (imem_instr == HALT_INSTR) begin
                            state_d = S_HALTED;
                        end
                    end
                end
                S_HALTED: begin
                    if (out_valid && out_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        halted_d = (state_d == S_HALTED);
    end

    // State, PC and output buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_pc    <= 32'd0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            out_valid <= valid_d;
            out_instr <= instr_d;
            out_pc    <= opc_d;
            halted    <= halted_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] count_d;

    // Count accepted instructions; a flushed entry is never counted. Saturates.
    always_comb begin
        count_d = fetch_count;
        if (out_valid && out_ready && !redirect_valid && fetch_count != 32'hFFFF_FFFF) begin
            count_d = fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else begin
            fetch_count <= count_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a driver applies directed and random
// stimulus and advances a transaction-level reference model that pushes each
// expected delivered instruction into a scoreboard queue; a monitor on the
// falling edge compares what the DUT presents and pops on every accepted transfer.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] rom [64];
    assign imem_instr = rom[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t exp_q[$];

    // Reference model: mode 0 = stopped, 1 = fetching, 2 = halted.
    int          m_mode = 0;
    logic [31:0] m_pc = 32'd0;
    bit          m_buf = 1'b0;
    logic [31:0] m_acc = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, req, $time);
        end
    endtask

    // Advance the model by one clock using the inputs that were applied.
    function automatic void model(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
        bit had = m_buf;
        ent_t e;
        if (r) begin
            if (had) e = exp_q.pop_back();
            m_buf = 1'b0;
            m_pc  = rp & 32'hFFFF_FFFC;
            if (m_mode != 0 || s) m_mode = 1;
        end else begin
            if (had && rdy) m_buf = 1'b0;
            if (m_mode == 0) begin
                if (s) m_mode = 1;
            end else if (m_mode == 1 && (!had || rdy)) begin
                e.pc    = m_pc;
                e.instr = rom[m_pc[7:2]];
                exp_q.push_back(e);
                m_buf = 1'b1;
                m_pc  = m_pc + 32'd4;
                if (e.instr == HALT) m_mode = 2;
            end
        end
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_pc   = 32'd0;
        m_buf  = 1'b0;
        m_acc  = 32'd0;
        exp_q.delete();
    endfunction

    // Driver step: called just after a rising edge, applies inputs for one cycle.
    task automatic step(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
        start          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        out_ready      = rdy;
        @(posedge clk);
        #1;
        model(s, r, rp, rdy);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, rdy);
    endtask

    // Monitor: compare presented state and consume accepted transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_buf});
            chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
            chk("imem_addr", {26'd0, imem_addr}, {26'd0, m_pc[7:2]});
`ifdef FETCH_PERF_EN
            chk("fetch_count", fetch_count, m_acc);
`endif
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    chk("out_pc", out_pc, exp_q[0].pc);
                    chk("out_instr", out_instr, exp_q[0].instr);
                    if (out_ready && !redirect_valid) begin
                        void'(exp_q.pop_front());
                        m_acc = m_acc + 32'd1;
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = $urandom & 32'h7FFF_FFFF;
        rom[0] = 32'd11;
        rom[1] = 32'd22;
        rom[2] = 32'd33;
        rom[3] = 32'd44;
        rom[4] = 32'd55;
        rom[5] = HALT;

        // Reset values.
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_imem_addr", {26'd0, imem_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Start, streaming, backpressure, redirect flush.
        step(1'b1, 1'b0, 32'd0, 1'b1);
        chk("start_latency_1", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("start_latency_2", {31'd0, out_valid}, 32'd1);
        chk("first_instr", out_instr, 32'd11);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("second_pc", out_pc, 32'd4);
        run(3, 1'b0);
        chk("stall_addr", {26'd0, imem_addr}, 32'd2);
        chk("stall_instr", out_instr, 32'd22);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("resume_instr", out_instr, 32'd33);
        step(1'b0, 1'b1, 32'h23, 1'b1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("redir_pc", out_pc, 32'h20);
        chk("redir_instr", out_instr, rom[8]);
        run(4, 1'b1);

        // Halt at 0x14, then restart by redirect to 0.
        step(1'b0, 1'b1, 32'h10, 1'b1);
        run(6, 1'b1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_last_pc", out_pc, 32'h14);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        chk("halt_ignores_start", {31'd0, halted}, 32'd1);
        step(1'b0, 1'b1, 32'd0, 1'b1);
        run(3, 1'b1);

        // Word-address wrap and 32-bit PC wrap.
        step(1'b0, 1'b1, 32'hFC, 1'b1);
        run(3, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        run(3, 1'b1);

        // Async reset while stalled.
        step(1'b0, 1'b1, 32'h40, 1'b1);
        run(2, 1'b1);
        run(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_imem_addr", {26'd0, imem_addr}, 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(3, 1'b1);
        step(1'b1, 1'b1, 32'h30, 1'b1);
        run(3, 1'b1);

        // Random phase with a reshuffled ROM containing a few halts.
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        for (int c = 0; c < 400; c++) begin
            bit s = ($urandom_range(0, 9) == 0);
            bit r = ($urandom_range(0, 11) == 0);
            bit rdy = ($urandom_range(0, 9) < 7);
            step(s, r, $urandom, rdy);
        end
        run(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
